// File: rtl/nibbler_pkg.sv
// Nibbler 4-bit processor shared definitions.
// Opcodes, ALU select codes and control FSM states.
package nibbler_pkg;

  localparam logic [3:0] OP_JC    = 4'd0;
  localparam logic [3:0] OP_JNC   = 4'd1;
  localparam logic [3:0] OP_CMPI  = 4'd2;
  localparam logic [3:0] OP_CMPM  = 4'd3;
  localparam logic [3:0] OP_LIT   = 4'd4;
  localparam logic [3:0] OP_IN    = 4'd5;
  localparam logic [3:0] OP_LD    = 4'd6;
  localparam logic [3:0] OP_ST    = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;
  localparam logic [3:0] OP_JNZ   = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_OUT   = 4'd11;
  localparam logic [3:0] OP_ADDI  = 4'd12;
  localparam logic [3:0] OP_ADDM  = 4'd13;
  localparam logic [3:0] OP_NANDI = 4'd14;
  localparam logic [3:0] OP_NANDM = 4'd15;

  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_CMP    = 3'd1;
  localparam logic [2:0] ALU_PASS_B = 3'd2;
  localparam logic [2:0] ALU_ADD    = 3'd3;
  localparam logic [2:0] ALU_NAND   = 3'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/nibbler_flags.sv
// Nibbler carry/zero flag register.
// Loads both flags together when we is high.
module nibbler_flags
  import nibbler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic c_in,
  input  logic z_in,
  output logic c_flag,
  output logic z_flag
);

  // flag register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (we) begin
      c_flag <= c_in;
      z_flag <= z_in;
    end
  end

endmodule

// File: rtl/nibbler_ctrl.sv
// Nibbler two-phase control unit: FETCH/EXEC FSM and decode.
// Define NIBBLER_WAIT_EN to add a WAIT state for memory/port ops.
module nibbler_ctrl
  import nibbler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       mem_rdy,
  output logic [2:0] alu_sel,
  output logic       b_from_mem,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_we,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       in_oe,
  output logic       out_we,
  output logic       c_flag,
  output logic       z_flag,
  output logic       phase
);

  state_t state_q, state_d;
  logic   exec, wait_op, flag_op, rdy, done;
  logic   acc_op, flags_we;

  assign wait_op = opcode inside {OP_CMPM, OP_IN, OP_LD, OP_ST,
                                  OP_OUT, OP_ADDM, OP_NANDM};
  assign flag_op = opcode inside {[OP_CMPI:OP_LD], [OP_ADDI:OP_NANDM]};

`ifdef NIBBLER_WAIT_EN
  assign rdy = mem_rdy | ~wait_op;
`else
  assign rdy = mem_rdy | 1'b1;
`endif

  assign exec     = (state_q != ST_FETCH);
  assign done     = exec & rdy;
  assign flags_we = done & flag_op & ~reset;
  assign phase    = exec & ~reset;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = (wait_op & ~rdy) ? ST_WAIT : ST_FETCH;
      ST_WAIT:  state_d = rdy ? ST_FETCH : ST_WAIT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // strobe decode; acc_we only on the completing cycle
  always_comb begin
    alu_sel    = ALU_PASS_A;
    b_from_mem = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_op     = 1'b0;
    mem_oe     = 1'b0;
    mem_we     = 1'b0;
    in_oe      = 1'b0;
    out_we     = 1'b0;
    if (!reset) begin
      if (!exec) begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end else begin
        unique case (opcode)
          OP_JC:    pc_load = c_flag;
          OP_JNC:   pc_load = ~c_flag;
          OP_CMPI:  alu_sel = ALU_CMP;
          OP_CMPM: begin
            alu_sel = ALU_CMP; mem_oe = 1'b1; b_from_mem = 1'b1;
          end
          OP_LIT: begin
            alu_sel = ALU_PASS_B; acc_op = 1'b1;
          end
          OP_IN: begin
            alu_sel = ALU_PASS_B; in_oe = 1'b1;
            b_from_mem = 1'b1; acc_op = 1'b1;
          end
          OP_LD: begin
            alu_sel = ALU_PASS_B; mem_oe = 1'b1;
            b_from_mem = 1'b1; acc_op = 1'b1;
          end
          OP_ST:    mem_we = 1'b1;
          OP_JZ:    pc_load = z_flag;
          OP_JNZ:   pc_load = ~z_flag;
          OP_JMP:   pc_load = 1'b1;
          OP_OUT:   out_we = 1'b1;
          OP_ADDI: begin
            alu_sel = ALU_ADD; acc_op = 1'b1;
          end
          OP_ADDM: begin
            alu_sel = ALU_ADD; mem_oe = 1'b1;
            b_from_mem = 1'b1; acc_op = 1'b1;
          end
          OP_NANDI: begin
            alu_sel = ALU_NAND; acc_op = 1'b1;
          end
          OP_NANDM: begin
            alu_sel = ALU_NAND; mem_oe = 1'b1;
            b_from_mem = 1'b1; acc_op = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign acc_we = acc_op & done;

  nibbler_flags u_flags (
    .clk    (clk),
    .reset  (reset),
    .we     (flags_we),
    .c_in   (alu_c),
    .z_in   (alu_z),
    .c_flag (c_flag),
    .z_flag (z_flag)
  );

endmodule
